// File: rtl/wb_arbiter_pkg.sv
// Shared register-file widths, constants and helpers for the write-back arbiter.
// Also holds the round-robin side encoding used by wb_arbiter.
package wb_arbiter_pkg;

    localparam int RegAddrWidth = 5;
    localparam int RegWidth     = 32;
    localparam int RegNum       = 1 << RegAddrWidth;

    typedef logic [RegAddrWidth-1:0] RegAddrBus;
    typedef logic [RegWidth-1:0]     RegBus;

    localparam logic      WriteEnable  = 1'b1;
    localparam logic      WriteDisable = 1'b0;
    localparam RegBus     ZeroWord     = '0;
    localparam RegAddrBus ZeroAddr     = '0;

    typedef enum logic {
        RR_ALU = 1'b0,
        RR_LSU = 1'b1
    } rr_e;

    function automatic logic [RegNum-1:0] reg_onehot(input RegAddrBus addr);
        logic [RegNum-1:0] mask;
        mask       = '0;
        mask[addr] = 1'b1;
        return mask;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Per-requester write buffer: DEPTH-entry circular FIFO of (register, value) pairs.
// Exposes per-slot valid bits and addresses so the arbiter can build the busy mask.
module wb_fifo
    import wb_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  RegAddrBus                push_addr,
    input  RegBus                    push_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output RegAddrBus                head_addr,
    output RegBus                    head_data,
    output logic [DEPTH-1:0]         entry_valid,
    output RegAddrBus                entry_addr [DEPTH]
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FullCount = (PW+1)'(DEPTH);

    RegAddrBus       addr_mem [DEPTH];
    RegBus           data_mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   offset;

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_ptr] <= push_addr;
            data_mem[wr_ptr] <= push_data;
        end
    end

    // A slot is live when its distance from the read pointer is below count.
    always_comb begin
        entry_valid = '0;
        offset      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offset         = PW'(i) - rd_ptr;
            entry_valid[i] = ({1'b0, offset} < count);
        end
    end

    assign full       = (count == FullCount);
    assign empty      = (count == '0);
    assign head_addr  = addr_mem[rd_ptr];
    assign head_data  = data_mem[rd_ptr];
    assign entry_addr = addr_mem;

endmodule

// File: rtl/wb_arbiter.sv
// Write-back arbiter: buffers ALU and LSU register writes and merges them
// round-robin onto the single register-file write port.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  RegAddrBus         alu_waddr,
    input  RegBus             alu_wdata,
    input  logic              lsu_valid,
    output logic              lsu_ready,
    input  RegAddrBus         lsu_waddr,
    input  RegBus             lsu_wdata,
    output logic              we,
    output RegAddrBus         waddr,
    output RegBus             wdata,
    output logic [RegNum-1:0] busy_mask
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FullCount = CW'(DEPTH);

    logic [CW-1:0]   alu_count, lsu_count;
    logic            alu_full, lsu_full, alu_empty, lsu_empty;
    RegAddrBus       alu_head_addr, lsu_head_addr;
    RegBus           alu_head_data, lsu_head_data;
    logic [DEPTH-1:0] alu_entry_valid, lsu_entry_valid;
    RegAddrBus       alu_entry_addr [DEPTH];
    RegAddrBus       lsu_entry_addr [DEPTH];
    logic            alu_push, lsu_push, alu_pop, lsu_pop;
    rr_e             rr;
    logic [RegNum-1:0] mask;

    assign alu_ready = rst && (alu_count < FullCount);
    assign lsu_ready = rst && (lsu_count < FullCount);

    // Writes to x0 complete the handshake but are never buffered.
    assign alu_push = alu_valid && alu_ready && rdy && !alu_full && (alu_waddr != ZeroAddr);
    assign lsu_push = lsu_valid && lsu_ready && rdy && !lsu_full && (lsu_waddr != ZeroAddr);

    assign alu_pop = rdy && !alu_empty && (lsu_empty || rr == RR_ALU);
    assign lsu_pop = rdy && !lsu_empty && !alu_pop;

    wb_fifo #(.DEPTH(DEPTH)) u_alu_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (alu_push),
        .pop        (alu_pop),
        .push_addr  (alu_waddr),
        .push_data  (alu_wdata),
        .count      (alu_count),
        .full       (alu_full),
        .empty      (alu_empty),
        .head_addr  (alu_head_addr),
        .head_data  (alu_head_data),
        .entry_valid(alu_entry_valid),
        .entry_addr (alu_entry_addr)
    );

    wb_fifo #(.DEPTH(DEPTH)) u_lsu_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (lsu_push),
        .pop        (lsu_pop),
        .push_addr  (lsu_waddr),
        .push_data  (lsu_wdata),
        .count      (lsu_count),
        .full       (lsu_full),
        .empty      (lsu_empty),
        .head_addr  (lsu_head_addr),
        .head_data  (lsu_head_data),
        .entry_valid(lsu_entry_valid),
        .entry_addr (lsu_entry_addr)
    );

    // After any pop, priority passes to the side that was not served.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr    <= RR_ALU;
            we    <= WriteDisable;
            waddr <= ZeroAddr;
            wdata <= ZeroWord;
        end else if (!rdy) begin
            we <= WriteDisable;
        end else if (alu_pop) begin
            rr    <= RR_LSU;
            we    <= WriteEnable;
            waddr <= alu_head_addr;
            wdata <= alu_head_data;
        end else if (lsu_pop) begin
            rr    <= RR_ALU;
            we    <= WriteEnable;
            waddr <= lsu_head_addr;
            wdata <= lsu_head_data;
        end else begin
            we <= WriteDisable;
        end
    end

    always_comb begin
        mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (alu_entry_valid[i]) mask = mask | reg_onehot(alu_entry_addr[i]);
            if (lsu_entry_valid[i]) mask = mask | reg_onehot(lsu_entry_addr[i]);
        end
        if (we) mask = mask | reg_onehot(waddr);
        mask[0]   = 1'b0;
        busy_mask = rst ? mask : '0;
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: a queue-level reference model predicts each
// register-file write; an independent monitor compares them as they appear.
module tb_wb_arbiter;
    import wb_arbiter_pkg::*;

    localparam int DEPTH = 2;

    logic              clk;
    logic              rst;
    logic              rdy;
    logic              alu_valid, lsu_valid;
    logic              alu_ready, lsu_ready;
    RegAddrBus         alu_waddr, lsu_waddr;
    RegBus             alu_wdata, lsu_wdata;
    logic              we;
    RegAddrBus         waddr;
    RegBus             wdata;
    logic [RegNum-1:0] busy_mask;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t        alu_q[$];
    wr_t        lsu_q[$];
    wr_t        exp_q[$];
    bit         rr_lsu;
    bit         m_we;
    logic [4:0] m_waddr;
    int         checks;
    int         failures;

    wb_arbiter #(.DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .rdy      (rdy),
        .alu_valid(alu_valid),
        .alu_ready(alu_ready),
        .alu_waddr(alu_waddr),
        .alu_wdata(alu_wdata),
        .lsu_valid(lsu_valid),
        .lsu_ready(lsu_ready),
        .lsu_waddr(lsu_waddr),
        .lsu_wdata(lsu_wdata),
        .we       (we),
        .waddr    (waddr),
        .wdata    (wdata),
        .busy_mask(busy_mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_busy();
        logic [31:0] m;
        m = '0;
        foreach (alu_q[i]) m[alu_q[i].addr] = 1'b1;
        foreach (lsu_q[i]) m[lsu_q[i].addr] = 1'b1;
        if (m_we) m[m_waddr] = 1'b1;
        m[0] = 1'b0;
        return m;
    endfunction

    task automatic check_output();
        check("alu_ready", 32'(alu_ready), 32'(rst && (alu_q.size() < DEPTH)));
        check("lsu_ready", 32'(lsu_ready), 32'(rst && (lsu_q.size() < DEPTH)));
        check("busy_mask", busy_mask, rst ? model_busy() : 32'h0);
    endtask

    // Predicts the effect of the coming clock edge from the queue contents.
    task automatic model_step();
        bit  alu_acc, lsu_acc, pop_alu, pop_lsu;
        wr_t w;
        if (!rdy) begin
            m_we = 1'b0;
            return;
        end
        alu_acc = alu_valid && (alu_q.size() < DEPTH) && (alu_waddr != 5'd0);
        lsu_acc = lsu_valid && (lsu_q.size() < DEPTH) && (lsu_waddr != 5'd0);
        pop_alu = 1'b0;
        pop_lsu = 1'b0;
        if (alu_q.size() > 0 && lsu_q.size() > 0) begin
            if (rr_lsu) pop_lsu = 1'b1;
            else        pop_alu = 1'b1;
        end else if (alu_q.size() > 0) begin
            pop_alu = 1'b1;
        end else if (lsu_q.size() > 0) begin
            pop_lsu = 1'b1;
        end
        m_we = pop_alu || pop_lsu;
        if (pop_alu) begin
            w = alu_q.pop_front();
            rr_lsu = 1'b1;
        end
        if (pop_lsu) begin
            w = lsu_q.pop_front();
            rr_lsu = 1'b0;
        end
        if (m_we) begin
            m_waddr = w.addr;
            exp_q.push_back(w);
        end
        if (alu_acc) alu_q.push_back({alu_waddr, alu_wdata});
        if (lsu_acc) lsu_q.push_back({lsu_waddr, lsu_wdata});
    endtask

    task automatic apply_stimulus(input logic r, input logic av, input logic [4:0] aa,
                                  input logic [31:0] ad, input logic lv,
                                  input logic [4:0] la, input logic [31:0] ld);
        @(negedge clk);
        check_output();
        rdy       = r;
        alu_valid = av;
        alu_waddr = aa;
        alu_wdata = ad;
        lsu_valid = lv;
        lsu_waddr = la;
        lsu_wdata = ld;
        model_step();
    endtask

    task automatic idle(input int n, input logic r);
        for (int i = 0; i < n; i++) apply_stimulus(r, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        check_output();
        rst       = 1'b0;
        alu_valid = 1'b0;
        lsu_valid = 1'b0;
        alu_q.delete();
        lsu_q.delete();
        rr_lsu  = 1'b0;
        m_we    = 1'b0;
        m_waddr = 5'd0;
        #1;
        check("rst_we", 32'(we), 32'h0);
        check("rst_alu_ready", 32'(alu_ready), 32'h0);
        check("rst_lsu_ready", 32'(lsu_ready), 32'h0);
        check("rst_busy_mask", busy_mask, 32'h0);
        repeat (2) begin
            @(negedge clk);
            check_output();
        end
        rst = 1'b1;
    endtask

    // Monitor: every write the DUT presents must match the oldest prediction.
    initial begin
        wr_t e;
        forever begin
            @(posedge clk);
            #1;
            if (we === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("[TB] FAIL unexpected_write: got x%0d=0x%08h, expected no write at %0t",
                             waddr, wdata, $time);
                end else begin
                    e = exp_q.pop_front();
                    if (waddr !== e.addr || wdata !== e.data) begin
                        failures++;
                        $display("[TB] FAIL write_data: got x%0d=0x%08h, expected x%0d=0x%08h at %0t",
                                 waddr, wdata, e.addr, e.data, $time);
                    end
                end
            end else if (exp_q.size() != 0) begin
                checks++;
                failures++;
                e = exp_q.pop_front();
                $display("[TB] FAIL missing_write: got we=%b, expected x%0d=0x%08h at %0t",
                         we, e.addr, e.data, $time);
            end
        end
    end

    initial begin
        checks    = 0;
        failures  = 0;
        rr_lsu    = 1'b0;
        m_we      = 1'b0;
        m_waddr   = 5'd0;
        rst       = 1'b0;
        rdy       = 1'b1;
        alu_valid = 1'b0;
        lsu_valid = 1'b0;
        alu_waddr = 5'd0;
        lsu_waddr = 5'd0;
        alu_wdata = 32'h0;
        lsu_wdata = 32'h0;
        #1;
        check("reset_we", 32'(we), 32'h0);
        check("reset_waddr", 32'(waddr), 32'h0);
        check("reset_wdata", wdata, 32'h0);
        check("reset_alu_ready", 32'(alu_ready), 32'h0);
        check("reset_lsu_ready", 32'(lsu_ready), 32'h0);
        check("reset_busy_mask", busy_mask, 32'h0);
        @(negedge clk);
        rst = 1'b1;

        $display("[TB] single write");
        apply_stimulus(1'b1, 1'b1, 5'd5, 32'h11, 1'b0, 5'd0, 32'h0);
        idle(3, 1'b1);

        $display("[TB] contention");
        apply_stimulus(1'b1, 1'b1, 5'd1, 32'hA, 1'b1, 5'd2, 32'hB);
        idle(3, 1'b1);
        apply_stimulus(1'b1, 1'b1, 5'd3, 32'hC, 1'b1, 5'd4, 32'hD);
        idle(3, 1'b1);

        $display("[TB] back-pressure");
        for (int i = 1; i <= 3; i++)
            apply_stimulus(1'b1, 1'b1, 5'(10 + i), 32'(i), 1'b1, 5'(20 + i), 32'(100 + i));
        apply_stimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd24, 32'd104);
        apply_stimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd24, 32'd104);
        apply_stimulus(1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd24, 32'd104);
        idle(6, 1'b1);

        $display("[TB] x0 drop");
        apply_stimulus(1'b1, 1'b1, 5'd0, 32'hFF, 1'b0, 5'd0, 32'h0);
        idle(3, 1'b1);

        $display("[TB] rdy stall");
        apply_stimulus(1'b1, 1'b1, 5'd7, 32'h77, 1'b1, 5'd8, 32'h88);
        idle(3, 1'b0);
        idle(4, 1'b1);

        $display("[TB] mid-stream reset");
        apply_stimulus(1'b1, 1'b1, 5'd9, 32'h99, 1'b1, 5'd10, 32'hAA);
        apply_stimulus(1'b1, 1'b1, 5'd11, 32'hBB, 1'b1, 5'd12, 32'hCC);
        do_reset();
        idle(4, 1'b1);

        $display("[TB] random traffic");
        for (int n = 0; n < 400; n++) begin
            apply_stimulus($urandom_range(0, 4) != 0,
                           1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
                           1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom);
            if (n == 200) do_reset();
        end

        for (int n = 0; n < 20 && (alu_q.size() + lsu_q.size()) > 0; n++) idle(1, 1'b1);
        idle(3, 1'b1);
        @(posedge clk);
        #2;
        check("expected_queue_drained", 32'(exp_q.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameter DEPTH, default 2, meaning per-requester buffer entries (power of two, at least 2).
REQ-002 SHALL have port clk, input, 1 bit: single clock, all state on posedge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have port rdy, input, 1 bit: global ready; low freezes all state.
REQ-005 SHALL have port alu_valid, input, 1 bit: ALU write request.
REQ-006 SHALL have port alu_ready, output, 1 bit: ALU buffer not full.
REQ-007 SHALL have ports alu_waddr (input, 5 bits) and alu_wdata (input, 32 bits): ALU destination register and value.
REQ-008 SHALL have ports lsu_valid, lsu_ready, lsu_waddr and lsu_wdata, identical to REQ-005..007, for the load/store unit.
REQ-009 SHALL have ports we (output, 1 bit), waddr (output, 5 bits) and wdata (output, 32 bits): the single register-file write port, all registered.
REQ-010 SHALL have port busy_mask, output, 32 bits: bit r set while any buffered or in-flight write targets register r.

Function
REQ-011 SHALL accept a request only when valid && ready && rdy are all high at the clock edge.
REQ-012 SHALL drive x_ready = (count_x < DEPTH); it depends only on registered count, never on x_valid.
REQ-013 SHALL consume an accepted request with waddr==0 without enqueuing it, so it never reaches we.
REQ-014 SHALL preserve FIFO order within each requester.
REQ-015 SHALL set no ordering between requesters; same-register hazards across requesters are resolved upstream.
REQ-016 SHALL, at each edge with rdy high, pop at most one entry across both buffers and register it onto we/waddr/wdata.
REQ-017 SHALL meet this latency: a handshake sampled at edge E, into an empty buffer with no contention, gives we=1 in the cycle after edge E+1.
REQ-018 SHALL arbitrate round-robin with pointer rr: if both buffers are non-empty, pop the rr side, then rr flips.
REQ-019 SHALL, if exactly one buffer is non-empty, pop it and set rr to the other side.
REQ-020 SHALL leave rr unchanged when both buffers are empty.
REQ-021 SHALL, at any edge with rdy high and nothing popped, register we=0 while waddr/wdata hold their values.
REQ-022 SHALL, at any edge with rdy low, perform no push and no pop, register we=0, and hold count, pointers and rr.
REQ-023 SHALL allow push and pop on the same buffer in one edge; count is then unchanged, including at count==DEPTH-1.
REQ-024 SHALL never push into a full buffer (REQ-012), and a pop from a full buffer re-asserts ready the next cycle.
REQ-025 SHALL wrap buffer pointers modulo DEPTH.
REQ-026 SHALL compute busy_mask combinationally as the OR of one-hot(waddr) over all valid buffer entries plus the output register when we=1; bit 0 is always 0.

Reset
REQ-027 SHALL, while rst=0, asynchronously clear: both counts and pointers to 0, rr to ALU, we=0, waddr=0, wdata=0.
REQ-028 SHALL force alu_ready=0, lsu_ready=0 and busy_mask=0 while rst=0.
REQ-029 SHALL discard all buffered entries when reset asserts mid-operation, and issue no write on the edge reset deasserts.

Structure
REQ-030 SHALL take RegAddrBus, RegBus, WriteEnable and ZeroWord from the shared defines file; no local width literals.
REQ-031 SHALL implement each requester buffer as sub-module wb_fifo (push, pop, count, full, empty, head, entry-valid vector), instantiated twice.
REQ-032 SHALL keep arbitration, rr, output registers and busy_mask in wb_arbiter itself.

Verification
REQ-033 SHALL test a single write: ALU (x5, 0x11) at edge 1 -> we=1, waddr=5, wdata=0x11 after edge 2; busy_mask[5]=1 from edge 1 until we drops.
REQ-034 SHALL test contention: ALU (x1, 0xA) and LSU (x2, 0xB) at the same edge, rr=ALU -> x1 written first, x2 next cycle, rr ends at ALU.
REQ-035 SHALL test back-pressure: 3 LSU requests back-to-back with no pops (rdy low after the first two) -> lsu_ready=0 after 2; rdy high -> one pop, ready=1 next cycle, order 1,2,3 kept.
REQ-036 SHALL test the x0 drop: ALU (x0, 0xFF) accepted -> alu_ready stays 1, we never asserts, busy_mask=0.
REQ-037 SHALL test a rdy stall: both buffers hold 1 entry, rdy low 3 cycles -> we=0 and counts unchanged; rdy high -> both drain in round-robin order.
REQ-038 SHALL test mid-stream reset: rst low with 2+1 entries buffered -> we=0, ready=0 and busy_mask=0 immediately; after release, no stale write appears.
